// File: rtl/axi4lite_rr_arbiter.sv
// axi4lite_rr_arbiter: two-master to one-slave AXI4-Lite round-robin arbiter, independent read/write FSMs
module axi4lite_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [ADDR_W-1:0]   S0_ARADDR,
  input  logic                S0_ARVALID,
  output logic                S0_ARREADY,
  output logic [DATA_W-1:0]   S0_RDATA,
  output logic [1:0]          S0_RRESP,
  output logic                S0_RVALID,
  input  logic                S0_RREADY,
  input  logic [ADDR_W-1:0]   S0_AWADDR,
  input  logic                S0_AWVALID,
  output logic                S0_AWREADY,
  input  logic [DATA_W-1:0]   S0_WDATA,
  input  logic [DATA_W/8-1:0] S0_WSTRB,
  input  logic                S0_WVALID,
  output logic                S0_WREADY,
  output logic [1:0]          S0_BRESP,
  output logic                S0_BVALID,
  input  logic                S0_BREADY,
  input  logic [ADDR_W-1:0]   S1_ARADDR,
  input  logic                S1_ARVALID,
  output logic                S1_ARREADY,
  output logic [DATA_W-1:0]   S1_RDATA,
  output logic [1:0]          S1_RRESP,
  output logic                S1_RVALID,
  input  logic                S1_RREADY,
  input  logic [ADDR_W-1:0]   S1_AWADDR,
  input  logic                S1_AWVALID,
  output logic                S1_AWREADY,
  input  logic [DATA_W-1:0]   S1_WDATA,
  input  logic [DATA_W/8-1:0] S1_WSTRB,
  input  logic                S1_WVALID,
  output logic                S1_WREADY,
  output logic [1:0]          S1_BRESP,
  output logic                S1_BVALID,
  input  logic                S1_BREADY,
  output logic [ADDR_W-1:0]   M_ARADDR,
  output logic                M_ARVALID,
  input  logic                M_ARREADY,
  input  logic [DATA_W-1:0]   M_RDATA,
  input  logic [1:0]          M_RRESP,
  input  logic                M_RVALID,
  output logic                M_RREADY,
  output logic [ADDR_W-1:0]   M_AWADDR,
  output logic                M_AWVALID,
  input  logic                M_AWREADY,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_WSTRB,
  output logic                M_WVALID,
  input  logic                M_WREADY,
  input  logic [1:0]          M_BRESP,
  input  logic                M_BVALID,
  output logic                M_BREADY,
  output logic [1:0]          rd_gnt_o,
  output logic [1:0]          wr_gnt_o
);
  localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2;
  logic [1:0] rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic rd_own_q, rd_own_d, rd_last_q, rd_last_d;
  logic wr_own_q, wr_own_d, wr_last_q, wr_last_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rd_a, rd_d, wr_x, wr_r;
  assign rd_a = rd_state_q == R_ADDR;
  assign rd_d = rd_state_q == R_DATA;
  assign wr_x = wr_state_q == W_XFER;
  assign wr_r = wr_state_q == W_RESP;
  assign rd_gnt_o = {(rd_a | rd_d) & rd_own_q, (rd_a | rd_d) & ~rd_own_q};
  assign wr_gnt_o = {(wr_x | wr_r) & wr_own_q, (wr_x | wr_r) & ~wr_own_q};
  assign M_ARADDR   = rd_a ? (rd_own_q ? S1_ARADDR : S0_ARADDR) : '0;
  assign M_ARVALID  = rd_a & (rd_own_q ? S1_ARVALID : S0_ARVALID);
  assign S0_ARREADY = rd_a & ~rd_own_q & M_ARREADY;
  assign S1_ARREADY = rd_a & rd_own_q & M_ARREADY;
  assign S0_RDATA   = (rd_d & ~rd_own_q) ? M_RDATA : '0;
  assign S1_RDATA   = (rd_d & rd_own_q) ? M_RDATA : '0;
  assign S0_RRESP   = (rd_d & ~rd_own_q) ? M_RRESP : 2'b00;
  assign S1_RRESP   = (rd_d & rd_own_q) ? M_RRESP : 2'b00;
  assign S0_RVALID  = rd_d & ~rd_own_q & M_RVALID;
  assign S1_RVALID  = rd_d & rd_own_q & M_RVALID;
  assign M_RREADY   = rd_d & (rd_own_q ? S1_RREADY : S0_RREADY);
  assign M_AWADDR   = wr_x ? (wr_own_q ? S1_AWADDR : S0_AWADDR) : '0;
  assign M_AWVALID  = wr_x & ~aw_done_q & (wr_own_q ? S1_AWVALID : S0_AWVALID);
  assign M_WDATA    = wr_x ? (wr_own_q ? S1_WDATA : S0_WDATA) : '0;
  assign M_WSTRB    = wr_x ? (wr_own_q ? S1_WSTRB : S0_WSTRB) : '0;
  assign M_WVALID   = wr_x & ~w_done_q & (wr_own_q ? S1_WVALID : S0_WVALID);
  assign S0_AWREADY = wr_x & ~wr_own_q & ~aw_done_q & M_AWREADY;
  assign S1_AWREADY = wr_x & wr_own_q & ~aw_done_q & M_AWREADY;
  assign S0_WREADY  = wr_x & ~wr_own_q & ~w_done_q & M_WREADY;
  assign S1_WREADY  = wr_x & wr_own_q & ~w_done_q & M_WREADY;
  assign S0_BRESP   = (wr_r & ~wr_own_q) ? M_BRESP : 2'b00;
  assign S1_BRESP   = (wr_r & wr_own_q) ? M_BRESP : 2'b00;
  assign S0_BVALID  = wr_r & ~wr_own_q & M_BVALID;
  assign S1_BVALID  = wr_r & wr_own_q & M_BVALID;
  assign M_BREADY   = wr_r & (wr_own_q ? S1_BREADY : S0_BREADY);
  // read FSM: on a tie the master that did not finish last wins
  always_comb begin
    rd_state_d = rd_state_q;
    rd_own_d   = rd_own_q;
    rd_last_d  = rd_last_q;
    if (rd_state_q == R_IDLE && (S0_ARVALID || S1_ARVALID)) begin
      rd_own_d   = (S0_ARVALID && S1_ARVALID) ? ~rd_last_q : S1_ARVALID;
      rd_state_d = R_ADDR;
    end
    if (rd_a && M_ARVALID && M_ARREADY) rd_state_d = R_DATA;
    if (rd_d && M_RVALID && M_RREADY) begin
      rd_last_d  = rd_own_q;
      rd_state_d = R_IDLE;
    end
  end
  // write FSM: AW and W complete independently, response waits for both
  always_comb begin
    wr_state_d = wr_state_q;
    wr_own_d   = wr_own_q;
    wr_last_d  = wr_last_q;
    aw_done_d  = aw_done_q | (M_AWVALID & M_AWREADY);
    w_done_d   = w_done_q | (M_WVALID & M_WREADY);
    if (wr_state_q == W_IDLE && (S0_AWVALID || S1_AWVALID)) begin
      wr_own_d   = (S0_AWVALID && S1_AWVALID) ? ~wr_last_q : S1_AWVALID;
      wr_state_d = W_XFER;
    end
    if (wr_x && aw_done_d && w_done_d) wr_state_d = W_RESP;
    if (wr_r && M_BVALID && M_BREADY) begin
      wr_last_d  = wr_own_q;
      aw_done_d  = 1'b0;
      w_done_d   = 1'b0;
      wr_state_d = W_IDLE;
    end
  end
  // state registers; reset abandons any transfer and points both pointers at M1
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      rd_own_q   <= 1'b0;
      rd_last_q  <= 1'b1;
      wr_state_q <= W_IDLE;
      wr_own_q   <= 1'b0;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_own_q   <= rd_own_d;
      rd_last_q  <= rd_last_d;
      wr_state_q <= wr_state_d;
      wr_own_q   <= wr_own_d;
      wr_last_q  <= wr_last_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end
endmodule
